// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling from a system-clock bit timer.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx #(
    parameter int SYS_CLOCK     = 50000000,
`ifdef UART_RX_PARITY_EN
    parameter bit PARITY_ODD    = 1'b0,
`endif
    parameter int UART_BAUDRATE = 115200
) (
    input  logic       i_SysClock,
    input  logic       i_Reset,
    input  logic       i_RxSerial,
    output logic [7:0] o_RxByte,
    output logic       o_RxValid,
    output logic       o_FrameErr,
    output logic       o_ParityErr,
    output logic       o_Busy
);
    localparam int BIT_CLKS  = SYS_CLOCK / UART_BAUDRATE;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_CLKS - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY_BIT = 3'd3,
`endif
        STOP_BIT   = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d, byte_q, byte_d;
    logic        valid_q, valid_d, ferr_q, ferr_d;
    logic        rxs, tick;
`ifdef UART_RX_PARITY_EN
    logic        perr_q, perr_d, pbad_q, pbad_d;
`endif

    assign rxs  = sync_q[1];
    // The start bit is timed to its middle; every later bit is a full period on.
    assign tick = timer_q == (state_q == START_BIT ? HALF_LAST : BIT_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
        pbad_d  = pbad_q;
`endif
        case (state_q)
            IDLE: state_d = rxs ? IDLE : START_BIT;
            START_BIT: if (tick) begin
                state_d = rxs ? IDLE : DATA_BITS;
                idx_d   = 3'd0;
            end
            DATA_BITS: if (tick) begin
                shift_d = {rxs, shift_q[7:1]};
                idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (idx_q == 3'd7) state_d = PARITY_BIT;
`else
                if (idx_q == 3'd7) state_d = STOP_BIT;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY_BIT: if (tick) begin
                pbad_d  = rxs != ((^shift_q) ^ PARITY_ODD);
                state_d = STOP_BIT;
            end
`endif
            STOP_BIT: if (tick) begin
                if (rxs) begin
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    valid_d = !pbad_q;
                    perr_d  = pbad_q;
                    byte_d  = pbad_q ? byte_q : shift_q;
`else
                    valid_d = 1'b1;
                    byte_d  = shift_q;
`endif
                end else begin
                    ferr_d  = 1'b1;
                    state_d = BREAK_WAIT;
                end
            end
            // A held-low line stays here so a break reports only one framing error.
            BREAK_WAIT: state_d = rxs ? IDLE : BREAK_WAIT;
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q || tick) ? 16'd0 : timer_q + 16'd1;
    end

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            timer_q <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], i_RxSerial};
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            pbad_q  <= pbad_d;
`endif
        end
    end

    assign o_RxByte   = byte_q;
    assign o_RxValid  = valid_q;
    assign o_FrameErr = ferr_q;
    assign o_Busy     = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
    assign o_ParityErr = perr_q;
`else
    assign o_ParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized serial frames checked against a frame-level model of uart_rx.
// A 10-clock/bit receiver cannot absorb one extra clock per bit over nine bits, so the
// slow-transmitter case runs on a 40-clock/bit instance driven at 41 clocks/bit.
module tb_uart_rx;
    localparam int BIT  = 10;
    localparam int WBIT = 40;

    logic clk = 1'b0, rst = 1'b1, ln0 = 1'b1, ln1 = 1'b1;
    logic [7:0] byte0, byte1;
    logic val0, val1, fe0, fe1, pe0, pe1, busy0, busy1;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    uart_rx #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000)) dut (
        .i_SysClock(clk), .i_Reset(rst), .i_RxSerial(ln0), .o_RxByte(byte0),
        .o_RxValid(val0), .o_FrameErr(fe0), .o_ParityErr(pe0), .o_Busy(busy0));
    uart_rx #(.SYS_CLOCK(4000000), .UART_BAUDRATE(100000)) u_wide (
        .i_SysClock(clk), .i_Reset(rst), .i_RxSerial(ln1), .o_RxByte(byte1),
        .o_RxValid(val1), .o_FrameErr(fe1), .o_ParityErr(pe1), .o_Busy(busy1));

    logic [7:0] got0[$], got1[$];
    int nfe0 = 0, npe0 = 0, nfe1 = 0, both = 0;
    logic prev_busy0 = 1'b0, fall_ok = 1'b0;
    always @(negedge clk) begin
        if (val0) begin
            got0.push_back(byte0);
            fall_ok = prev_busy0 && !busy0;
        end
        if (val1) got1.push_back(byte1);
        if (fe0) nfe0++;
        if (pe0) npe0++;
        if (fe1) nfe1++;
        if ((val0 && (fe0 || pe0)) || (val1 && (fe1 || pe1))) both++;
        prev_busy0 = busy0;
    end

    int b_got0, b_got1, b_fe0, b_pe0;
    logic [7:0] last_good = 8'h00;

    task automatic mark();
        b_got0 = got0.size();
        b_got1 = got1.size();
        b_fe0  = nfe0;
        b_pe0  = npe0;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) ln1 = v;
        else ln0 = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input int clks, input logic stop_v, input bit par_flip);
        set_line(sel, 1'b0);
        repeat (clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, b[i]);
            repeat (clks) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        set_line(sel, logic'(($countones(b) % 2) != 0) ^ par_flip);
        repeat (clks) @(negedge clk);
`else
        if (par_flip) set_line(sel, 1'b1);
`endif
        set_line(sel, stop_v);
        repeat (clks) @(negedge clk);
        set_line(sel, 1'b1);
    endtask

    // Frame outcome from the line-level rules: 0 good byte, 1 framing error, 2 parity error.
    function automatic int outcome(input logic stop_v, input bit par_flip);
        if (!stop_v) return 1;
`ifdef UART_RX_PARITY_EN
        if (par_flip) return 2;
`else
        if (par_flip) return 0;
`endif
        return 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (byte0 !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", byte0); end
        total++; if (val0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", val0); end
        total++; if (fe0 !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", fe0); end
        total++; if (pe0 !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", pe0); end
        total++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b exp=00", busy0, busy1); end
    endtask

    task automatic test_single();
        mark();
        send(1'b0, 8'hA5, BIT, 1'b1, 1'b0);
        for (int i = 0; i < 20 * BIT && got0.size() == b_got0; i++) @(negedge clk);
        repeat (BIT) @(negedge clk);
        last_good = 8'hA5;
        total++; if (got0.size() - b_got0 != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got0.size() - b_got0); end
        else begin
            total++; if (got0[b_got0] !== 8'hA5) begin bad++; $display("FAIL single_byte got=%h exp=a5", got0[b_got0]); end
        end
        total++; if (nfe0 != b_fe0) begin bad++; $display("FAIL single_ferr got=%0d exp=0", nfe0 - b_fe0); end
        total++; if (fall_ok !== 1'b1) begin bad++; $display("FAIL single_busy_fall got=%b exp=1", fall_ok); end
        total++; if (byte0 !== 8'hA5) begin bad++; $display("FAIL single_hold got=%h exp=a5", byte0); end
    endtask

    task automatic run_stream(input bit sel, input int clks, input string name);
        logic [7:0] exp[$];
        logic [7:0] b;
        exp = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 5; i++) exp.push_back(8'($urandom_range(255)));
        mark();
        foreach (exp[i]) send(sel, exp[i], clks, 1'b1, 1'b0);
        repeat (3 * clks) @(negedge clk);
        if (!sel) last_good = exp[exp.size() - 1];
        total++;
        if ((sel ? got1.size() - b_got1 : got0.size() - b_got0) != exp.size()) begin
            bad++;
            $display("FAIL %s_count got=%0d exp=%0d", name, sel ? got1.size() - b_got1 : got0.size() - b_got0, exp.size());
        end else begin
            foreach (exp[i]) begin
                b = sel ? got1[b_got1 + i] : got0[b_got0 + i];
                total++; if (b !== exp[i]) begin bad++; $display("FAIL %s_byte%0d got=%h exp=%h", name, i, b, exp[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        run_stream(1'b0, BIT, "b2b");
    endtask

    task automatic test_tolerance();
        run_stream(1'b1, WBIT + 1, "slow_tx");
        total++; if (nfe1 != 0) begin bad++; $display("FAIL slow_tx_ferr got=%0d exp=0", nfe1); end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        mark();
        ln0 = 1'b0;
        repeat (3) @(negedge clk);
        ln0 = 1'b1;
        for (int i = 0; i < 2 * BIT; i++) begin
            @(negedge clk);
            seen |= busy0;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen got=%b exp=1", seen); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", busy0); end
        total++; if (got0.size() != b_got0 || nfe0 != b_fe0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", got0.size() - b_got0 + nfe0 - b_fe0); end
        total++; if (byte0 !== last_good) begin bad++; $display("FAIL glitch_hold got=%h exp=%h", byte0, last_good); end
    endtask

    task automatic test_break();
        mark();
        send(1'b0, 8'h55, BIT, 1'b0, 1'b0);
        ln0 = 1'b0;
        repeat (50) @(negedge clk);
        ln0 = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        total++; if (nfe0 - b_fe0 != 1) begin bad++; $display("FAIL break_ferr got=%0d exp=1", nfe0 - b_fe0); end
        total++; if (got0.size() != b_got0) begin bad++; $display("FAIL break_valid got=%0d exp=0", got0.size() - b_got0); end
        total++; if (byte0 !== last_good) begin bad++; $display("FAIL break_hold got=%h exp=%h", byte0, last_good); end
        mark();
        send(1'b0, 8'h12, BIT, 1'b1, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        last_good = 8'h12;
        total++; if (got0.size() != b_got0 + 1 || byte0 !== 8'h12) begin bad++; $display("FAIL break_next got=%h exp=12", byte0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'h81;
        mark();
        ln0 = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ln0 = b[i];
            repeat (i == 4 ? BIT / 2 : BIT) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ln0 = 1'b1;
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy0); end
        repeat (3 * BIT) @(negedge clk);
        total++; if (got0.size() != b_got0 || nfe0 != b_fe0) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=0", got0.size() - b_got0 + nfe0 - b_fe0); end
        total++; if (byte0 !== 8'h00) begin bad++; $display("FAIL rstmid_byte got=%h exp=00", byte0); end
        mark();
        send(1'b0, 8'h7E, BIT, 1'b1, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        last_good = 8'h7E;
        total++; if (got0.size() != b_got0 + 1 || byte0 !== 8'h7E) begin bad++; $display("FAIL rstmid_next got=%h exp=7e", byte0); end
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        int efe = 0, epe = 0, k;
        mark();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b = 8'($urandom_range(255));
            logic stop_v = $urandom_range(4) != 0;
            bit flip = $urandom_range(3) == 0;
            send(1'b0, b, BIT, stop_v, flip);
            k = outcome(stop_v, flip);
            if (k == 0) begin exp.push_back(b); last_good = b; end
            if (k == 1) efe++;
            if (k == 2) epe++;
            repeat ((stop_v ? $urandom_range(2) : 1 + $urandom_range(1)) * BIT) @(negedge clk);
        end
        repeat (2 * BIT) @(negedge clk);
        total++; if (nfe0 - b_fe0 != efe) begin bad++; $display("FAIL rand_ferr got=%0d exp=%0d", nfe0 - b_fe0, efe); end
        total++; if (npe0 - b_pe0 != epe) begin bad++; $display("FAIL rand_perr got=%0d exp=%0d", npe0 - b_pe0, epe); end
        total++;
        if (got0.size() - b_got0 != exp.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got0.size() - b_got0, exp.size()); end
        else foreach (exp[i]) begin
            total++; if (got0[b_got0 + i] !== exp[i]) begin bad++; $display("FAIL rand_byte%0d got=%h exp=%h", i, got0[b_got0 + i], exp[i]); end
        end
        total++; if (byte0 !== last_good) begin bad++; $display("FAIL rand_hold got=%h exp=%h", byte0, last_good); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        mark();
        send(1'b0, 8'h03, BIT, 1'b1, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        last_good = 8'h03;
        total++; if (got0.size() != b_got0 + 1 || byte0 !== 8'h03) begin bad++; $display("FAIL parity_good got=%h exp=03", byte0); end
        mark();
        send(1'b0, 8'h03, BIT, 1'b1, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        total++; if (npe0 - b_pe0 != 1) begin bad++; $display("FAIL parity_err got=%0d exp=1", npe0 - b_pe0); end
        total++; if (got0.size() != b_got0) begin bad++; $display("FAIL parity_valid got=%0d exp=0", got0.size() - b_got0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_tolerance();
        test_glitch();
        test_break();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        total++; if (both != 0) begin bad++; $display("FAIL exclusive_pulses got=%0d exp=0", both); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
